// File: rtl/conv_arbiter.sv
// conv_arbiter
// Round-robin arbiter sharing one pipelined int-to-float converter among NREQ requesters.
// At most one request is accepted per cycle; its operand is registered onto unit_x and its
// requester ID travels down a valid/id shift register matched to the converter latency, so
// each result leaves tagged with the ID that issued it.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   en         grant enable; 0 blocks new grants, in-flight work still drains
//   req_valid  per-requester operand valid
//   req_data   per-requester 32-bit two's-complement operand, requester i in [32*i +: 32]
//   req_ready  one-hot grant
//   unit_x     registered operand to the external converter
//   unit_y     converter result
//   resp_valid result valid this cycle
//   resp_id    requester that issued the returning operation
//   resp_data  converter result (pass-through of unit_y)
//   inflight   accepted operations not yet returned
module conv_arbiter #(
    parameter int unsigned  NREQ = 4,
    parameter int unsigned  LAT  = 3,
    localparam int unsigned IDW  = $clog2(NREQ),
    localparam int unsigned CNTW = $clog2(LAT + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          unit_x,
    input  logic [31:0]          unit_y,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_data,
    output logic [CNTW-1:0]      inflight
);

    localparam logic [IDW-1:0] LastId = IDW'(NREQ - 1);

    logic [IDW-1:0]  r_ptr;
    logic [31:0]     r_unit_x;
    logic [LAT:0]    r_vld;
    logic [IDW-1:0]  r_id [LAT+1];
    logic [CNTW-1:0] r_inflight;

    logic            w_found;
    logic            w_accept;
    logic [IDW-1:0]  w_gnt;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [CNTW-1:0] w_inflight_nxt;
    logic [31:0]     w_data [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_data[i] = req_data[32*i +: 32];
    end

    // Scan starting at the round-robin pointer; the sum is kept one bit wider so the
    // modulo-NREQ wrap works for non-power-of-two NREQ.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_sum[IDW-1:0];
            end
        end
    end

    // Gating with rst keeps req_ready low while reset is held.
    assign w_accept  = w_found & en & ~rst;
    assign req_ready = w_accept ? (NREQ'(1) << w_gnt) : '0;
    assign w_ptr_nxt = (w_gnt == LastId) ? '0 : w_gnt + IDW'(1);

    always_comb begin
        w_inflight_nxt = r_inflight;
        unique case ({w_accept, r_vld[LAT]})
            2'b10:   w_inflight_nxt = r_inflight + CNTW'(1);
            2'b01:   w_inflight_nxt = r_inflight - CNTW'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_unit_x   <= '0;
            r_vld      <= '0;
            r_inflight <= '0;
            for (int s = 0; s <= LAT; s++) begin
                r_id[s] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_ptr    <= w_ptr_nxt;
                r_unit_x <= w_data[w_gnt];
            end
            r_vld   <= {r_vld[LAT-1:0], w_accept};
            r_id[0] <= w_accept ? w_gnt : '0;
            for (int s = 1; s <= LAT; s++) begin
                r_id[s] <= r_id[s-1];
            end
            r_inflight <= w_inflight_nxt;
        end
    end

    assign unit_x     = r_unit_x;
    assign resp_valid = r_vld[LAT];
    assign resp_id    = r_id[LAT];
    assign resp_data  = unit_y;
    assign inflight   = r_inflight;

endmodule

// File: tb/tb_conv_arbiter.sv
// Bench for conv_arbiter: table-driven single requests, hand-written multi-cycle sequences
// and a randomized phase, all checked against a transaction-level model of grants and
// tagged responses. The external converter is modelled here as a LAT-deep pipeline.
module tb_conv_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 3;
    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned CNTW = $clog2(LAT + 2);

    logic                clk;
    logic                rst;
    logic                en;
    logic [NREQ-1:0]     req_valid;
    logic [32*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [31:0]         unit_x;
    logic [31:0]         unit_y;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_data;
    logic [CNTW-1:0]     inflight;

    logic [31:0]         tb_data [NREQ];
    int unsigned         cyc;
    int                  checks;
    int                  failures;

    conv_arbiter #(
        .NREQ(NREQ),
        .LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .unit_x    (unit_x),
        .unit_y    (unit_y),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .inflight  (inflight)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = tb_data[i];
    end

    // Integer to IEEE-754 single, round to nearest even.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic        s;
        logic [31:0] a, m, rem, half;
        int          p, sh;
        logic [7:0]  e;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        a = s ? (~x + 32'd1) : x;
        p = 31;
        while (!a[p]) p--;
        if (p <= 23) begin
            m = a << (23 - p);
        end else begin
            sh   = p - 23;
            m    = a >> sh;
            rem  = a & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 32'd1;
            if (m[24]) begin
                m = m >> 1;
                p++;
            end
        end
        e = 8'(p + 127);
        return {s, e, m[22:0]};
    endfunction

    // External converter: no reset, fixed latency.
    logic [31:0] cpipe [LAT];
    always @(posedge clk) begin
        cpipe[0] <= i2f(unit_x);
        for (int s = 1; s < LAT; s++) cpipe[s] <= cpipe[s-1];
    end
    assign unit_y = cpipe[LAT-1];

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=none required=event (cycle %0d)", name, cyc);
    endfunction

    // Reference model: pending responses with the cycle they are due in.
    typedef struct {
        int unsigned due;
        int          id;
        logic [31:0] f;
    } pend_t;

    pend_t       sb_q[$];
    int unsigned m_ptr;

    always @(negedge clk) begin : sb
        int              g;
        int              idx;
        logic [NREQ-1:0] exp_rdy;
        if (rst) begin
            sb_q.delete();
            m_ptr = 0;
            chk("rst_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_id", resp_id, 0);
        end else begin
            g = -1;
            if (en) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (int'(m_ptr) + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
            chk("sb_grant", req_ready, exp_rdy);
            chk("sb_inflight", inflight, sb_q.size());
            while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                fail_now("sb_missing_resp");
                void'(sb_q.pop_front());
            end
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                chk("sb_resp_valid", resp_valid, 1);
                chk("sb_resp_id", resp_id, sb_q[0].id);
                chk("sb_resp_data", resp_data, sb_q[0].f);
                void'(sb_q.pop_front());
            end else begin
                chk("sb_resp_idle", resp_valid, 0);
            end
            if (g >= 0) begin
                sb_q.push_back('{due: cyc + 1 + LAT, id: g, f: i2f(tb_data[g])});
                m_ptr = (g + 1) % NREQ;
            end
        end
    end

    task automatic run_single(input int id, input logic [31:0] d, input logic [31:0] e);
        int unsigned acc;
        bit          seen;
        @(posedge clk); #1;
        tb_data[id] = d;
        req_valid   = NREQ'(1) << id;
        @(negedge clk);
        chk("single_grant", req_ready, NREQ'(1) << id);
        acc = cyc;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("single_inflight", inflight, 1);
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            if (resp_valid) begin
                seen = 1'b1;
                chk("single_latency", cyc - acc, 1 + LAT);
                chk("single_id", resp_id, id);
                chk("single_data", resp_data, e);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) fail_now("single_timeout");
    endtask

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int              g;
        int              prev;
        int              nresp;
        int unsigned     last;
        int              order [3];
        logic [NREQ-1:0] last_rdy;

        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst      = 1'b1;
        en       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) tb_data[i] = '0;

        vecs[0] = '{2, 32'h0000_0002, 32'h4000_0000};
        vecs[1] = '{2, 32'hFFFF_FFFF, 32'hBF80_0000};
        vecs[2] = '{3, 32'd255,       32'h437F_0000};
        vecs[3] = '{0, 32'd1234567890, 32'h4E93_2C06};
        vecs[4] = '{1, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1, 32'h8000_0000, 32'hCF00_0000};
        vecs[6] = '{0, 32'h0000_0001, 32'h3F80_0000};
        vecs[7] = '{3, 32'd16777217,  32'h4B80_0000};
        vecs[8] = '{1, 32'h7FFF_FFFF, 32'h4F00_0000};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (10) begin
            @(negedge clk);
            chk("idle_ready", req_ready, 0);
            chk("idle_resp_valid", resp_valid, 0);
            chk("idle_inflight", inflight, 0);
        end

        foreach (vecs[v]) run_single(vecs[v].id, vecs[v].data, vecs[v].exp);

        // All requesters valid continuously
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) tb_data[i] = $urandom;
        req_valid = '1;
        prev = -1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            g = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            if (n > 0) chk("full_rr_order", g, (prev + 1) % NREQ);
            if (n >= int'(LAT) + 1) begin
                chk("full_inflight", inflight, LAT + 1);
                chk("full_resp_valid", resp_valid, 1);
            end
            prev = g;
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (LAT + 2) @(negedge clk);

        // Fairness after wrap: request from 2 leaves the pointer at 3
        run_single(2, 32'd2, 32'h4000_0000);
        @(posedge clk); #1;
        tb_data[0] = 32'd1234567890;
        tb_data[3] = 32'd255;
        req_valid  = 4'b1001;
        order[0] = 3;
        order[1] = 0;
        order[2] = 3;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("wrap_grant", req_ready, NREQ'(1) << order[n]);
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (LAT + 2) @(negedge clk);

        // Drain with en low
        @(posedge clk); #1;
        tb_data[1] = $urandom;
        req_valid  = 4'b0010;
        last = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("drain_grant", req_ready, 4'b0010);
            last = cyc;
            @(posedge clk); #1;
        end
        en = 1'b0;
        nresp = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("drain_ready", req_ready, 0);
            if (resp_valid) nresp++;
            if (cyc == last + LAT + 1) chk("drain_inflight_one", inflight, 1);
            if (cyc == last + LAT + 2) chk("drain_inflight_zero", inflight, 0);
        end
        chk("drain_count", nresp, 3);
        req_valid = '0;
        en = 1'b1;

        // Reset two cycles after an accept
        @(posedge clk); #1;
        tb_data[0] = $urandom;
        req_valid  = 4'b0001;
        @(negedge clk);
        chk("mrst_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nresp = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        chk("mrst_no_resp", nresp, 0);
        run_single(2, 32'd7, 32'h40E0_0000);

        // Randomized traffic; data held while a requester waits
        last_rdy = '0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !last_rdy[i])) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    tb_data[i]   = $urandom;
                end
            end
            @(negedge clk);
            last_rdy = req_ready;
        end
        @(posedge clk); #1;
        req_valid = '0;
        en = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        chk("final_inflight", inflight, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
